// File: rtl/spi_arbiter_if.sv
// -----------------------------------------------------------------------------
// spi_arbiter_if
//
// Bundles every signal between the two requesters, the arbiter and the SPI
// command/data port.
//   Requester n (n = 0/1):
//     reqn, cmdn, wrn, rdn, lockn : requester -> arbiter, levels
//     dinn[10:0]                  : requester -> arbiter, transfer payload
//     ackn, errn                  : arbiter -> requester, one-cycle pulses
//     doutn[8:0]                  : arbiter -> requester, received byte
//   SPI block side:
//     spi_cmd, spi_wr, spi_rd     : arbiter -> SPI, one-cycle strobes
//     spi_din[10:0]               : arbiter -> SPI, payload
//     spi_dout[8:0], spi_ack      : SPI -> arbiter, read data and completion
//   Status:
//     owner[1:0] (one-hot), busy  : arbiter -> observers
// The arbiter connects through the slave modport; the requester/SPI
// environment drives the master modport.
// -----------------------------------------------------------------------------
interface spi_arbiter_if;
  logic        req0, req1;
  logic        cmd0, cmd1;
  logic        wr0, wr1;
  logic        rd0, rd1;
  logic        lock0, lock1;
  logic [10:0] din0, din1;
  logic        ack0, ack1;
  logic        err0, err1;
  logic [8:0]  dout0, dout1;

  logic        spi_cmd, spi_wr, spi_rd;
  logic [10:0] spi_din;
  logic [8:0]  spi_dout;
  logic        spi_ack;

  logic [1:0]  owner;
  logic        busy;

  modport slave (
    input  req0, req1, cmd0, cmd1, wr0, wr1, rd0, rd1, lock0, lock1,
    input  din0, din1, spi_dout, spi_ack,
    output ack0, ack1, err0, err1, dout0, dout1,
    output spi_cmd, spi_wr, spi_rd, spi_din, owner, busy
  );

  modport master (
    output req0, req1, cmd0, cmd1, wr0, wr1, rd0, rd1, lock0, lock1,
    output din0, din1, spi_dout, spi_ack,
    input  ack0, ack1, err0, err1, dout0, dout1,
    input  spi_cmd, spi_wr, spi_rd, spi_din, owner, busy
  );
endinterface

// File: rtl/spi_arbiter.sv
// -----------------------------------------------------------------------------
// spi_arbiter
//
// Shares the single command/data port of the SPI block between two
// requesters. Grants are round-robin on ties, a granted owner may lock the
// port across several transfers (a chip-select frame is never interleaved),
// and a watchdog completes a transfer with an error if the SPI block never
// acknowledges it.
//
// Parameters:
//   TIMEOUT : WAIT cycles tolerated without spi_ack (0 disables the watchdog)
//   TO_W    : watchdog counter width, TIMEOUT < 2**TO_W
// Ports:
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   bus     : spi_arbiter_if.slave, requester and SPI signals
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module spi_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    HOLD  = 3'd4
  } state_e;

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);
  localparam bit              TO_EN  = (TIMEOUT != 0);

  state_e      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic        last_q, last_d;       // 1 = port 1 was served last
  logic        busy_q, busy_d;
  logic        spi_cmd_q, spi_cmd_d;
  logic        spi_wr_q, spi_wr_d;
  logic        spi_rd_q, spi_rd_d;
  logic [10:0] spi_din_q, spi_din_d;
  logic [1:0]  ack_q, ack_d;
  logic [1:0]  err_q, err_d;
  logic [8:0]  dout0_q, dout0_d;
  logic [8:0]  dout1_q, dout1_d;
  logic [TO_W-1:0] wd_q, wd_d;

  // Grant request shared by IDLE (arbitration) and HOLD (locked re-issue).
  logic do_grant;
  logic grant1;

  // Owner's live request/lock levels, used in DONE and HOLD.
  logic owner_req;
  logic owner_lock;

  // Completion bookkeeping from WAIT.
  logic       do_finish;
  logic       finish_err;
  logic [8:0] finish_data;

  assign owner_req  = owner_q[1] ? bus.req1  : bus.req0;
  assign owner_lock = owner_q[1] ? bus.lock1 : bus.lock0;

  // NOTE: every signal driven here gets a default first so no path through
  // the case leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    spi_cmd_d   = 1'b0;
    spi_wr_d    = 1'b0;
    spi_rd_d    = 1'b0;
    spi_din_d   = spi_din_q;
    ack_d       = 2'b00;
    err_d       = 2'b00;
    dout0_d     = dout0_q;
    dout1_d     = dout1_q;
    wd_d        = wd_q;
    do_grant    = 1'b0;
    grant1      = 1'b0;
    do_finish   = 1'b0;
    finish_err  = 1'b0;
    finish_data = 9'h000;

    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          do_grant = 1'b1;
          // On a tie the port not served last wins.
          grant1   = bus.req1 && (!bus.req0 || !last_q);
        end
      end

      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT;
      end

      WAIT: begin
        if (wd_q != '1) begin
          wd_d = wd_q + 1'b1;
        end
        // A late spi_ack in the timeout cycle still counts as success.
        if (bus.spi_ack) begin
          do_finish   = 1'b1;
          finish_data = bus.spi_dout;
        end else if (TO_EN && (wd_q == TO_LIM)) begin
          do_finish  = 1'b1;
          finish_err = 1'b1;
        end
      end

      DONE: begin
        // The owner's req is deliberately not looked at here.
        if (owner_lock) begin
          state_d = HOLD;
        end else begin
          state_d = IDLE;
          owner_d = 2'b00;
        end
      end

      HOLD: begin
        if (owner_req) begin
          do_grant = 1'b1;
          grant1   = owner_q[1];
        end else if (!owner_lock) begin
          state_d = IDLE;
          owner_d = 2'b00;
        end
      end

      default: begin
        state_d = IDLE;
        owner_d = 2'b00;
      end
    endcase

    if (do_grant) begin
      state_d   = ISSUE;
      owner_d   = grant1 ? 2'b10 : 2'b01;
      spi_din_d = grant1 ? bus.din1 : bus.din0;
      spi_cmd_d = grant1 ? bus.cmd1 : bus.cmd0;
      spi_wr_d  = grant1 ? bus.wr1  : bus.wr0;
      spi_rd_d  = grant1 ? bus.rd1  : bus.rd0;
    end

    if (do_finish) begin
      state_d = DONE;
      ack_d   = owner_q;
      err_d   = finish_err ? owner_q : 2'b00;
      last_d  = owner_q[1];
      if (owner_q[1]) begin
        dout1_d = finish_data;
      end else begin
        dout0_d = finish_data;
      end
    end
  end

  // busy is registered from the next state so it lines up with state_q.
  assign busy_d = (state_d != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= 2'b00;
      last_q    <= 1'b1;
      busy_q    <= 1'b0;
      spi_cmd_q <= 1'b0;
      spi_wr_q  <= 1'b0;
      spi_rd_q  <= 1'b0;
      spi_din_q <= 11'h000;
      ack_q     <= 2'b00;
      err_q     <= 2'b00;
      dout0_q   <= 9'h000;
      dout1_q   <= 9'h000;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      spi_cmd_q <= spi_cmd_d;
      spi_wr_q  <= spi_wr_d;
      spi_rd_q  <= spi_rd_d;
      spi_din_q <= spi_din_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      dout0_q   <= dout0_d;
      dout1_q   <= dout1_d;
      wd_q      <= wd_d;
    end
  end

  assign bus.owner   = owner_q;
  assign bus.busy    = busy_q;
  assign bus.spi_cmd = spi_cmd_q;
  assign bus.spi_wr  = spi_wr_q;
  assign bus.spi_rd  = spi_rd_q;
  assign bus.spi_din = spi_din_q;
  assign bus.ack0    = ack_q[0];
  assign bus.ack1    = ack_q[1];
  assign bus.err0    = err_q[0];
  assign bus.err1    = err_q[1];
  assign bus.dout0   = dout0_q;
  assign bus.dout1   = dout1_q;

endmodule

// File: doc/spi_arbiter.md
# spi_arbiter

Two-port arbiter sharing the single command/data port of the SPI interface block between two requesters, e.g. the Wishbone bridge and an autonomous polling engine. It grants the port round-robin and forwards one strobe per transfer. It returns the received byte and an acknowledge to the owning requester. It supports locked multi-byte bursts, so a chip-select frame is never interleaved, and a watchdog terminates transfers the SPI side never acknowledges.

## Interface
- TIMEOUT, 255: max cycles waited for spi_ack; 0 disables watchdog
- TO_W, 8: watchdog counter width; TIMEOUT < 2^TO_W
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- req0 / req1  in  1  requester n wants a transfer; held until ackn
- cmd0 / cmd1, wr0 / wr1, rd0 / rd1  in  1 each  transfer kind, level, stable while reqn high
- din0 / din1  in  11  transfer payload, stable while reqn high
- lock0 / lock1  in  1  keep ownership after this transfer (burst)
- ack0 / ack1  out  1  one-cycle done pulse
- err0 / err1  out  1  one-cycle pulse coincident with ackn on timeout
- dout0 / dout1  out  9  received data, valid from ackn until next ackn
- spi_cmd, spi_wr, spi_rd  out  1 each  one-cycle strobes to SPI block
- spi_din  out  11  payload to SPI block, registered at grant
- spi_dout  in  9  data from SPI block
- spi_ack  in  1  SPI block completion pulse
- owner  out  2  one-hot current owner, 00 when free
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, ISSUE, WAIT, DONE, HOLD.
- IDLE: if any req, pick winner, set owner, register winner's din/cmd/wr/rd, go to ISSUE. Both requesting: winner is the one not served last. last_served resets to 1, so port 0 wins the first tie.
- ISSUE (1 cycle): spi_cmd/spi_wr/spi_rd = registered kind bits, forwarded unchanged. Watchdog cleared. Go to WAIT.
- WAIT: watchdog increments each cycle.
  - spi_ack high: latch spi_dout into doutN, go to DONE.
  - Watchdog reaches TIMEOUT (TIMEOUT≠0) with no spi_ack: doutN = 0x000, set error flag, go to DONE.
  - spi_ack arriving in the same cycle as timeout counts as success.
- DONE (1 cycle): ackN = 1, errN = error flag, last_served = owner.
  - Owner's req is ignored in this cycle; requesters drop or re-present req after ack.
  - lockN high (sampled in DONE): go to HOLD, else go to IDLE with owner cleared.
- HOLD: owner kept, other port ignored.
  - Owner req high: register its fields, go to ISSUE.
  - Else if lockN low: clear owner, go to IDLE.
  - Owner req and lock both low: IDLE.
- Non-owner req during ISSUE/WAIT/DONE/HOLD is queued implicitly (level) and evaluated at next IDLE.
- Reset (any state, mid-transfer included): state IDLE, owner 00, busy 0, all strobes/acks/errs 0, dout0/dout1 0x000, spi_din 0x000, watchdog 0, last_served 1. A pending spi_ack after reset is ignored.

## Timing
- All outputs registered. No combinational path from req*/spi_ack to any output.
- req sampled at edge k in IDLE → owner/busy/spi_din and strobe valid cycle k+1 (ISSUE). Strobe is exactly one cycle.
- spi_ack sampled at edge m → ackN/doutN valid cycle m+1. Next grant is at earliest m+3 (ISSUE) from IDLE, or m+3 from HOLD.
- Timeout: ackN/errN assert TIMEOUT+2 cycles after the ISSUE cycle.
- Watchdog saturates; no wrap.
- Throughput, unlocked back-to-back single port: one transfer per SPI latency + 4 cycles.

## Test plan
- Single transfer: req0, wr0=1, din0=0x1A5. Expect spi_wr pulse 1 cycle with spi_din=0x1A5 and owner=01. spi_ack with spi_dout=0x03C 5 cycles later → ack0 next cycle, dout0=0x03C, err0=0, busy 0 two cycles later.
- Tie: req0 and req1 asserted same cycle after reset. Expect port 0 first, then port 1. Repeat tie → port 1 served before port 0 only if port 0 was last; verify strict alternation over 8 transfers.
- Burst lock: port 1 with lock1=1 for 3 transfers while req0 held high. Expect no port-0 grant until lock1 drops, then port 0 granted next IDLE.
- Timeout: TIMEOUT=16, no spi_ack. Expect ack0=err0=1 in one cycle, 18 cycles after ISSUE, dout0=0x000. spi_ack coincident with the timeout cycle → err0=0.
- Reset mid-WAIT: rst low for 1 cycle during WAIT. Expect all outputs 0 immediately, owner 00. Late spi_ack produces no ack. Next tie grants port 0.
